// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Multicycle signed divider for the multicycle MIPS datapath
//               (DIV instruction). One restoring step per clock on operand
//               magnitudes, followed by a sign-fix cycle.
//               HI <= remainder, LO <= quotient.
//
//               A start in IDLE with a zero divisor skips straight to DONE
//               and flags DivZero. HI/LO keep their previous values.
//
// Ports       : clock       - system clock, rising edge
//               reset       - synchronous, active-high reset
//               DivA        - dividend
//               DivB        - divisor
//               DivCtrl     - start request (only honoured in IDLE)
//               DivUnsigned - DIVU select, sampled with DivCtrl
//                             (present only with DIV_UNSIGNED_EN)
//               DivDone     - one-cycle completion pulse
//               DivZero     - divisor was zero, valid with DivDone
//               counter     - iteration index (debug)
//               DivHIOut    - remainder
//               DivLOOut    - quotient
//
// Optional    : define DIV_UNSIGNED_EN to add the DivUnsigned input.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] DivA,
    input  logic [WIDTH-1:0] DivB,
    input  logic             DivCtrl,
`ifdef DIV_UNSIGNED_EN
    input  logic             DivUnsigned,
`endif
    output logic             DivDone,
    output logic             DivZero,
    output logic [CNT_W-1:0] counter,
    output logic [WIDTH-1:0] DivHIOut,
    output logic [WIDTH-1:0] DivLOOut
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next;

    logic [WIDTH-1:0] r_rem;     // partial remainder
    logic [WIDTH-1:0] r_dvd;     // dividend magnitude, becomes the quotient
    logic [WIDTH-1:0] r_div;     // divisor magnitude
    logic             r_sign_a;
    logic             r_sign_b;

    logic             w_unsigned;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    logic             w_start;
    logic             w_step;
    logic             w_fix;
    logic             w_done_nxt;
    logic             w_zero_nxt;

`ifdef DIV_UNSIGNED_EN
    assign w_unsigned = DivUnsigned;
`else
    assign w_unsigned = 1'b0;
`endif

    // Forcing the sign bits to zero in unsigned mode also disables the
    // negation in the FIX cycle.
    assign w_sign_a = DivA[WIDTH-1] & ~w_unsigned;
    assign w_sign_b = DivB[WIDTH-1] & ~w_unsigned;
    // Magnitudes are plain WIDTH-bit values, so |most-negative| wraps to itself
    // and is still the correct unsigned magnitude.
    assign w_abs_a  = w_sign_a ? (-DivA) : DivA;
    assign w_abs_b  = w_sign_b ? (-DivB) : DivB;

    // Restoring step on {rem, dvd} shifted left by one. The extra MSB of the
    // trial difference is its sign.
    assign w_shift  = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial  = w_shift - {1'b0, r_div};

    // Truncating division: the quotient sign is the XOR of the operand signs,
    // and the remainder takes the dividend's sign.
    assign w_q_fix  = (r_sign_a ^ r_sign_b) ? (-r_dvd) : r_dvd;
    assign w_r_fix  = r_sign_a ? (-r_rem) : r_rem;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (DivCtrl) begin
                    w_next = (DivB == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (counter == CNT_W'(WIDTH - 1)) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control decode. DivDone/DivZero are registered from these, so they
    // are high exactly while the FSM sits in DONE.
    // ------------------------------------------------------------------
    always_comb begin
        w_start    = (r_state == S_IDLE) && DivCtrl;
        w_step     = (r_state == S_CALC);
        w_fix      = (r_state == S_FIX);
        w_done_nxt = (w_next == S_DONE);
        w_zero_nxt = w_start && (DivB == '0);
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rem    <= '0;
            r_dvd    <= '0;
            r_div    <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            counter  <= '0;
            DivDone  <= 1'b0;
            DivZero  <= 1'b0;
            DivHIOut <= '0;
            DivLOOut <= '0;
        end else begin
            DivDone <= w_done_nxt;
            DivZero <= w_zero_nxt;

            if (w_start) begin
                r_sign_a <= w_sign_a;
                r_sign_b <= w_sign_b;
                r_dvd    <= w_abs_a;
                r_div    <= w_abs_b;
                r_rem    <= '0;
                counter  <= '0;
            end

            if (w_step) begin
                if (!w_trial[WIDTH]) begin
                    r_rem <= w_trial[WIDTH-1:0];
                end else begin
                    r_rem <= w_shift[WIDTH-1:0];
                end
                r_dvd   <= {r_dvd[WIDTH-2:0], ~w_trial[WIDTH]};
                counter <= counter + CNT_W'(1);
            end

            if (w_fix) begin
                DivHIOut <= w_r_fix;
                DivLOOut <= w_q_fix;
            end

            if (r_state == S_DONE) begin
                counter <= '0;
            end
        end
    end

endmodule
`default_nettype wire
